count_mode_arbiter: RTL and testbench
=====================================

# count_mode_arbiter

Two-requester round-robin arbiter and sequencer for the shared 4-bit even/odd mode counter. It grants one requester at a time and drives the counter's 2-bit mode input. It watches the counter value fed back on `z_in` and stops the counter exactly on the requester's target value. Each completed grant is reported with a done pulse.

## Interface
- `MAX_CYCLES`, default 16: RUN-cycle limit per grant for the timeout feature; legal range 1..31.
- `clk`  in  1  posedge clock
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  2  request, one bit per requester; level-held until `done`
- `mode0`, `mode1`  in  2 each  requested counter mode: 00 even, 01 odd, 10 load 15, 11 dwell
- `target0`, `target1`  in  4 each  stop value; for dwell, the dwell length
- `z_in`  in  4  current counter value Z
- `a_out`  out  2  counter mode input A; 11 = hold
- `gnt`  out  2  one-hot grant, registered
- `done`  out  2  one-cycle completion pulse per requester
- `aborted`  out  1  valid with `done`: 1 = grant ended without reaching target

## Operation
- FSM states are IDLE, RUN and GAP.
- Reset state:
  - FSM in IDLE; `a_out`=11; `gnt`=00; `done`=00; `aborted`=0.
  - Round-robin pointer favours requester 0.
- IDLE
  - `a_out`=11.
  - If any `req` bit is set, pick a winner:
    - a single requester wins outright;
    - if both request, the one not served last wins (requester 0 after reset).
  - At the clock edge: capture the winner's mode and target, set `gnt`, clear `run_cnt`, go to RUN.
- RUN
  - `run_cnt` counts RUN cycles starting at 0.
  - The burst terminates in a cycle if any of these holds:
    - match: modes 00/01/10 when `z_in`==target; mode 11 when `run_cnt`==target;
    - drop: the granted `req` bit is 0;
    - timeout: `run_cnt`==MAX_CYCLES-1.
  - Termination priority: match > drop > timeout.
  - `a_out` is combinational:
    - terminating cycle: 11;
    - otherwise: the captured mode, so the counter steps at that edge.
  - The counter is therefore never stepped past the target.
  - At the edge after the terminating cycle:
    - `gnt`←00;
    - `done[i]`←1 for the granted requester;
    - `aborted`←1 if the cause was drop or timeout, else 0;
    - pointer set so the other requester gets priority next;
    - go to GAP.
- GAP
  - Lasts exactly one cycle; `a_out`=11, `done` pulses, then go to IDLE.
  - Requests are ignored during GAP.
- The block does not prevent unreachable targets (e.g. an odd target in even mode); the timeout ends such bursts.
- `mode`/`target` inputs may change while granted; only the values captured at grant are used.

## Timing
- Grant latency: `req` seen in IDLE → `gnt` and `a_out`=mode on the next cycle.
- If the target already equals `z_in` in the first RUN cycle, the burst completes in 1 RUN cycle with zero counter steps.
- `done` and `aborted` arrive 1 cycle after the terminating RUN cycle.
- Minimum dead time between bursts is 2 cycles (GAP, then IDLE).
- Mode 11 target N → N+1 RUN cycles, subject to the timeout.
- Reset mid-RUN: immediate return to reset state; no `done` is issued.
- `run_cnt` is 5 bits; compares are unsigned; it saturates and does not wrap.

## Configuration
- `COUNT_ARB_TIMEOUT_EN` defined:
  - timeout termination active as described above.
- `COUNT_ARB_TIMEOUT_EN` undefined:
  - no timeout; a burst ends only on match or drop;
  - `MAX_CYCLES` is unused;
  - `run_cnt` is still kept for dwell.

## Structure
- Package `count_arb_pkg` holds:
  - state enum `IDLE`/`RUN`/`GAP`;
  - mode constants `MODE_EVEN`=00, `MODE_ODD`=01, `MODE_LOAD15`=10, `MODE_HOLD`=11;
  - `RUN_CNT_W`=5.
- Sub-module `rr_arb2`: two-way round-robin picker with pointer register and one-hot grant.
- Top: FSM, capture registers, `run_cnt`, termination and `a_out` logic.
- Bench connects the mode counter (A=`a_out`, Z=`z_in`) as the load.

## Test plan
- Reset; req0, mode 00, target 6 → 4 RUN cycles with Z=0,2,4,6; `a_out`=11 when Z=6; `done[0]`=1, `aborted`=0; Z holds at 6.
- Then req1, mode 01, target 3 → Z 6→1→3 over 3 RUN cycles; `done[1]`; Z holds at 3.
- Both request simultaneously after reset → requester 0 served first, then 1; a second round with both requesting → 0 then 1 again, each separated by ≥2 dead cycles.
- req0, mode 00, target 5, `COUNT_ARB_TIMEOUT_EN`, MAX_CYCLES=16 → 16 RUN cycles, then `done[0]` with `aborted`=1. Without the macro → still RUN after 40 cycles.
- req1, mode 11, target 3 → 4 RUN cycles with `a_out`=11 and Z unchanged; `done[1]`, `aborted`=0. Mode 10, target 15 from Z=3 → 2 RUN cycles, Z=15.
- req0 dropped in its 3rd RUN cycle → `a_out`=11 in that cycle; `done[0]` and `aborted`=1 next cycle. Reset asserted mid-RUN → `gnt`=00, `a_out`=11, no `done`.

Source files
------------

// File: rtl/count_mode_arbiter_pkg.sv
// Shared types and constants for the count-mode arbiter slice:
// FSM state encoding, counter mode codes and the run counter width.
package count_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      GAP  = 2'b10
   } state_t;

   localparam logic [1:0] MODE_EVEN   = 2'b00;
   localparam logic [1:0] MODE_ODD    = 2'b01;
   localparam logic [1:0] MODE_LOAD15 = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;

   localparam int RUN_CNT_W = 5;

   // Saturating increment: the run counter sticks at all-ones instead of wrapping.
   function automatic logic [RUN_CNT_W-1:0] sat_inc(input logic [RUN_CNT_W-1:0] v);
      logic [RUN_CNT_W-1:0] r;
      if (&v) begin
         r = v;
      end else begin
         r = v + {{(RUN_CNT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   // One-hot two-bit vector from a requester index.
   function automatic logic [1:0] idx_to_oh(input logic idx);
      logic [1:0] r;
      if (idx) begin
         r = 2'b10;
      end else begin
         r = 2'b01;
      end
      return r;
   endfunction

endpackage

// File: rtl/count_mode_arbiter_if.sv
// Bus between the two requesters / mode counter and the count-mode arbiter.
// master: requester and counter side; slave: the arbiter.
interface count_mode_arbiter_if;

   logic [1:0] req;
   logic [1:0] mode0;
   logic [1:0] mode1;
   logic [3:0] target0;
   logic [3:0] target1;
   logic [3:0] z_in;
   logic [1:0] a_out;
   logic [1:0] gnt;
   logic [1:0] done;
   logic       aborted;

   modport master (
      output req, mode0, mode1, target0, target1, z_in,
      input  a_out, gnt, done, aborted
   );

   modport slave (
      input  req, mode0, mode1, target0, target1, z_in,
      output a_out, gnt, done, aborted
   );

endinterface

// File: rtl/count_mode_arbiter_rr_arb2.sv
// Two-way round-robin picker. The pointer names the requester that wins a
// tie; after a burst it is moved to the requester that was not served.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       served,
   output logic [1:0] win,
   output logic       win_idx
);

   logic ptr_r;

   // Winner selection: a lone requester wins, a tie goes to the pointer.
   always_comb begin
      win = 2'b00;
      case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11: begin
            if (ptr_r) begin
               win = 2'b10;
            end else begin
               win = 2'b01;
            end
         end
         default: win = 2'b00;
      endcase
      win_idx = win[1];
   end

   // Pointer register: hands priority to the other requester after a burst.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_r <= 1'b0;
      end else if (update) begin
         ptr_r <= ~served;
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule

// File: rtl/count_mode_arbiter.sv
// Round-robin arbiter and sequencer for the shared 4-bit even/odd mode
// counter. Grants one requester, steps the counter in the captured mode and
// holds it (A=11) in the very cycle Z reaches the target, so the counter is
// never stepped past it.
// Optional feature macro: COUNT_ARB_TIMEOUT_EN (RUN-cycle limit MAX_CYCLES).
module count_mode_arbiter
   import count_arb_pkg::*;
#(
   parameter int MAX_CYCLES = 16
) (
   input logic               clk,
   input logic               reset,
   count_mode_arbiter_if.slave bus
);

   state_t               state_r;
   logic [1:0]           gnt_r;
   logic [1:0]           done_r;
   logic                 aborted_r;
   logic [1:0]           mode_cap_r;
   logic [3:0]           target_cap_r;
   logic [RUN_CNT_W-1:0] run_cnt_r;
   logic                 sel_r;

   logic [1:0]           win_s;
   logic                 win_idx_s;
   logic [1:0]           mode_sel_s;
   logic [3:0]           target_sel_s;
   logic                 match_s;
   logic                 drop_s;
   logic                 timeout_s;
   logic                 term_s;
   logic                 arb_update_s;
   logic [1:0]           a_out_s;

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .reset   (reset),
      .req     (bus.req),
      .update  (arb_update_s),
      .served  (sel_r),
      .win     (win_s),
      .win_idx (win_idx_s)
   );

   // Mode/target of the current arbitration winner, captured on grant.
   always_comb begin
      if (win_idx_s) begin
         mode_sel_s   = bus.mode1;
         target_sel_s = bus.target1;
      end else begin
         mode_sel_s   = bus.mode0;
         target_sel_s = bus.target0;
      end
   end

   // Match: dwell compares the RUN-cycle count, all other modes compare Z.
   always_comb begin
      match_s = 1'b0;
      if (mode_cap_r == MODE_HOLD) begin
         match_s = ({1'b0, target_cap_r} == run_cnt_r);
      end else begin
         match_s = (bus.z_in == target_cap_r);
      end
   end

   // Drop: the granted requester has released its request.
   always_comb begin
      if (sel_r) begin
         drop_s = ~bus.req[1];
      end else begin
         drop_s = ~bus.req[0];
      end
   end

`ifdef COUNT_ARB_TIMEOUT_EN
   localparam logic [RUN_CNT_W-1:0] RUN_LAST = RUN_CNT_W'(MAX_CYCLES - 1);

   // Timeout: the last allowed RUN cycle of this grant.
   always_comb begin
      timeout_s = (run_cnt_r == RUN_LAST);
   end
`else
   logic unused_cfg_s;
   assign unused_cfg_s = (MAX_CYCLES > 0);

   // Timeout disabled: bursts end only on match or drop.
   always_comb begin
      timeout_s = 1'b0;
   end
`endif

   // Burst termination and round-robin update; match outranks drop/timeout.
   always_comb begin
      if (state_r == RUN) begin
         term_s = match_s | drop_s | timeout_s;
      end else begin
         term_s = 1'b0;
      end
      arb_update_s = term_s;
   end

   // Counter mode: step in the captured mode unless the burst ends now.
   always_comb begin
      if ((state_r == RUN) && !term_s) begin
         a_out_s = mode_cap_r;
      end else begin
         a_out_s = MODE_HOLD;
      end
   end

   // Sequencer FSM with registered grant, done and aborted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         gnt_r        <= 2'b00;
         done_r       <= 2'b00;
         aborted_r    <= 1'b0;
         mode_cap_r   <= MODE_HOLD;
         target_cap_r <= 4'd0;
         run_cnt_r    <= {RUN_CNT_W{1'b0}};
         sel_r        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r    <= 2'b00;
               aborted_r <= 1'b0;
               if (|win_s) begin
                  gnt_r        <= win_s;
                  sel_r        <= win_idx_s;
                  mode_cap_r   <= mode_sel_s;
                  target_cap_r <= target_sel_s;
                  run_cnt_r    <= {RUN_CNT_W{1'b0}};
                  state_r      <= RUN;
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               if (term_s) begin
                  gnt_r     <= 2'b00;
                  done_r    <= idx_to_oh(sel_r);
                  aborted_r <= ~match_s;
                  state_r   <= GAP;
               end else begin
                  run_cnt_r <= sat_inc(run_cnt_r);
                  state_r   <= RUN;
               end
            end
            GAP: begin
               done_r    <= 2'b00;
               aborted_r <= 1'b0;
               state_r   <= IDLE;
            end
            default: begin
               gnt_r     <= 2'b00;
               done_r    <= 2'b00;
               aborted_r <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   assign bus.a_out   = a_out_s;
   assign bus.gnt     = gnt_r;
   assign bus.done    = done_r;
   assign bus.aborted = aborted_r;

endmodule

// File: tb/tb_count_mode_arbiter.sv
// Self-checking bench for count_mode_arbiter with a model of the 4-bit
// even/odd mode counter as the load (A = a_out, Z = z_in).
module tb_count_mode_arbiter;

   logic clk;
   logic reset;
   logic [3:0] z_r;

   int n_cmp = 0;
   int n_err = 0;

   count_mode_arbiter_if bus ();

   count_mode_arbiter #(.MAX_CYCLES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mode counter: even walks even values (odd Z restarts at 0), odd walks
   // odd values (even Z restarts at 1), 10 loads 15, 11 holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         z_r <= 4'd0;
      end else begin
         case (bus.a_out)
            2'b00:   z_r <= z_r[0] ? 4'd0 : z_r + 4'd2;
            2'b01:   z_r <= z_r[0] ? z_r + 4'd2 : 4'd1;
            2'b10:   z_r <= 4'd15;
            default: z_r <= z_r;
         endcase
      end
   end
   assign bus.z_in = z_r;

   typedef struct {
      logic [1:0] req;
      logic [1:0] m0;
      logic [3:0] t0;
      logic [1:0] m1;
      logic [3:0] t1;
      logic [1:0] g;
      logic [1:0] a;
      logic [1:0] d;
      logic       ab;
      logic [3:0] z;
   } vec_t;

   vec_t tbl [27];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.req     = 2'b00;
      bus.mode0   = 2'b00;
      bus.mode1   = 2'b00;
      bus.target0 = 4'd0;
      bus.target1 = 4'd0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // Waits for a grant, counts its RUN cycles, checks the done/aborted
   // report, then releases that request. Entry sample counts as dead time.
   task automatic serve(input string nm, input logic [1:0] exp_g, input logic exp_ab,
                        input int exp_run, input int min_idle);
      int idle;
      int runc;
      int guard;
      idle  = 0;
      runc  = 0;
      guard = 0;
      while (bus.gnt == 2'b00 && guard < 60) begin
         idle++;
         guard++;
         step();
      end
      chk({nm, "_gnt"}, 32'(bus.gnt), 32'(exp_g));
      chk({nm, "_dead"}, 32'(idle >= min_idle), 32'd1);
      guard = 0;
      while (bus.gnt != 2'b00 && guard < 60) begin
         runc++;
         guard++;
         step();
      end
      chk({nm, "_runcyc"}, 32'(runc), 32'(exp_run));
      chk({nm, "_done"}, 32'(bus.done), 32'(exp_g));
      chk({nm, "_aborted"}, 32'(bus.aborted), 32'(exp_ab));
      bus.req = bus.req & ~exp_g;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      //            req    m0     t0     m1     t1     gnt    a_out  done   ab    z
      tbl[0]  = '{2'b01, 2'b00, 4'd6,  2'b00, 4'd0, 2'b00, 2'b11, 2'b00, 1'b0, 4'd0};
      tbl[1]  = '{2'b01, 2'b00, 4'd6,  2'b00, 4'd0, 2'b01, 2'b00, 2'b00, 1'b0, 4'd0};
      tbl[2]  = '{2'b01, 2'b00, 4'd6,  2'b00, 4'd0, 2'b01, 2'b00, 2'b00, 1'b0, 4'd2};
      tbl[3]  = '{2'b01, 2'b00, 4'd6,  2'b00, 4'd0, 2'b01, 2'b00, 2'b00, 1'b0, 4'd4};
      tbl[4]  = '{2'b01, 2'b00, 4'd6,  2'b00, 4'd0, 2'b01, 2'b11, 2'b00, 1'b0, 4'd6};
      tbl[5]  = '{2'b00, 2'b00, 4'd6,  2'b00, 4'd0, 2'b00, 2'b11, 2'b01, 1'b0, 4'd6};
      tbl[6]  = '{2'b10, 2'b00, 4'd0,  2'b01, 4'd3, 2'b00, 2'b11, 2'b00, 1'b0, 4'd6};
      tbl[7]  = '{2'b10, 2'b00, 4'd0,  2'b01, 4'd3, 2'b10, 2'b01, 2'b00, 1'b0, 4'd6};
      tbl[8]  = '{2'b10, 2'b00, 4'd0,  2'b00, 4'd1, 2'b10, 2'b01, 2'b00, 1'b0, 4'd1};
      tbl[9]  = '{2'b10, 2'b00, 4'd0,  2'b00, 4'd1, 2'b10, 2'b11, 2'b00, 1'b0, 4'd3};
      tbl[10] = '{2'b00, 2'b00, 4'd0,  2'b00, 4'd1, 2'b00, 2'b11, 2'b10, 1'b0, 4'd3};
      tbl[11] = '{2'b10, 2'b00, 4'd0,  2'b11, 4'd3, 2'b00, 2'b11, 2'b00, 1'b0, 4'd3};
      tbl[12] = '{2'b10, 2'b00, 4'd0,  2'b11, 4'd3, 2'b10, 2'b11, 2'b00, 1'b0, 4'd3};
      tbl[13] = '{2'b10, 2'b00, 4'd0,  2'b11, 4'd3, 2'b10, 2'b11, 2'b00, 1'b0, 4'd3};
      tbl[14] = '{2'b10, 2'b00, 4'd0,  2'b11, 4'd3, 2'b10, 2'b11, 2'b00, 1'b0, 4'd3};
      tbl[15] = '{2'b10, 2'b00, 4'd0,  2'b11, 4'd3, 2'b10, 2'b11, 2'b00, 1'b0, 4'd3};
      tbl[16] = '{2'b00, 2'b00, 4'd0,  2'b11, 4'd3, 2'b00, 2'b11, 2'b10, 1'b0, 4'd3};
      tbl[17] = '{2'b01, 2'b10, 4'd15, 2'b00, 4'd0, 2'b00, 2'b11, 2'b00, 1'b0, 4'd3};
      tbl[18] = '{2'b01, 2'b10, 4'd15, 2'b00, 4'd0, 2'b01, 2'b10, 2'b00, 1'b0, 4'd3};
      tbl[19] = '{2'b00, 2'b10, 4'd15, 2'b00, 4'd0, 2'b01, 2'b11, 2'b00, 1'b0, 4'd15};
      tbl[20] = '{2'b00, 2'b10, 4'd15, 2'b00, 4'd0, 2'b00, 2'b11, 2'b01, 1'b0, 4'd15};
      tbl[21] = '{2'b01, 2'b00, 4'd8,  2'b00, 4'd0, 2'b00, 2'b11, 2'b00, 1'b0, 4'd15};
      tbl[22] = '{2'b01, 2'b00, 4'd8,  2'b00, 4'd0, 2'b01, 2'b00, 2'b00, 1'b0, 4'd15};
      tbl[23] = '{2'b01, 2'b00, 4'd8,  2'b00, 4'd0, 2'b01, 2'b00, 2'b00, 1'b0, 4'd0};
      tbl[24] = '{2'b00, 2'b00, 4'd8,  2'b00, 4'd0, 2'b01, 2'b11, 2'b00, 1'b0, 4'd2};
      tbl[25] = '{2'b00, 2'b00, 4'd8,  2'b00, 4'd0, 2'b00, 2'b11, 2'b01, 1'b1, 4'd2};
      tbl[26] = '{2'b00, 2'b00, 4'd8,  2'b00, 4'd0, 2'b00, 2'b11, 2'b00, 1'b0, 4'd2};

      // Reset state
      do_reset();
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_a_out", 32'(bus.a_out), 32'd3);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_aborted", 32'(bus.aborted), 32'd0);

      // Cycle-by-cycle vectors: even, odd (with live input change), dwell,
      // load 15 (match beating a simultaneous drop), and a drop abort.
      for (int i = 0; i < 27; i++) begin
         @(negedge clk);
         bus.req     = tbl[i].req;
         bus.mode0   = tbl[i].m0;
         bus.target0 = tbl[i].t0;
         bus.mode1   = tbl[i].m1;
         bus.target1 = tbl[i].t1;
         #1;
         chk($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].g));
         chk($sformatf("v%0d_a_out", i), 32'(bus.a_out), 32'(tbl[i].a));
         chk($sformatf("v%0d_done", i), 32'(bus.done), 32'(tbl[i].d));
         chk($sformatf("v%0d_aborted", i), 32'(bus.aborted), 32'(tbl[i].ab));
         chk($sformatf("v%0d_z", i), 32'(z_r), 32'(tbl[i].z));
      end

      // Both request after reset: 0 then 1; second round 0 then 1 again
      // with requester 0 re-requesting while 1 is still waiting.
      do_reset();
      bus.req     = 2'b11;
      bus.mode0   = 2'b00;
      bus.target0 = 4'd2;
      bus.mode1   = 2'b01;
      bus.target1 = 4'd1;
      serve("both_r1_0", 2'b01, 1'b0, 2, 1);
      serve("both_r1_1", 2'b10, 1'b0, 2, 2);
      bus.req     = 2'b11;
      bus.target0 = 4'd4;
      bus.target1 = 4'd5;
      serve("both_r2_0", 2'b01, 1'b0, 4, 2);
      bus.req = 2'b11;
      serve("both_r2_1", 2'b10, 1'b0, 4, 2);
      chk("both_r2_z", 32'(z_r), 32'd5);
      bus.req = 2'b00;

      // Unreachable target (odd in even mode)
      do_reset();
      bus.req     = 2'b01;
      bus.mode0   = 2'b00;
      bus.target0 = 4'd5;
`ifdef COUNT_ARB_TIMEOUT_EN
      serve("timeout", 2'b01, 1'b1, 16, 1);
`else
      repeat (42) step();
      chk("notmo_gnt", 32'(bus.gnt), 32'd1);
      chk("notmo_a_out", 32'(bus.a_out), 32'd0);
      bus.req = 2'b00;
      #1;
      chk("notmo_drop_a_out", 32'(bus.a_out), 32'd3);
      step();
      chk("notmo_done", 32'(bus.done), 32'd1);
      chk("notmo_aborted", 32'(bus.aborted), 32'd1);
`endif

      // Reset asserted mid-RUN
      do_reset();
      bus.req     = 2'b01;
      bus.mode0   = 2'b00;
      bus.target0 = 4'd14;
      step();
      step();
      step();
      chk("midrst_pre_gnt", 32'(bus.gnt), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_gnt", 32'(bus.gnt), 32'd0);
      chk("midrst_a_out", 32'(bus.a_out), 32'd3);
      chk("midrst_done", 32'(bus.done), 32'd0);
      step();
      reset   = 1'b0;
      bus.req = 2'b00;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("midrst_post%0d_done", k), 32'(bus.done), 32'd0);
         chk($sformatf("midrst_post%0d_gnt", k), 32'(bus.gnt), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
